// File: rtl/lsu_pkg.sv
// lsu_pkg: load/store opcodes, FSM states and opcode decode shared by the LSU files
package lsu_pkg;
  typedef enum logic [3:0] {LB, LBU, LH, LHU, LW, LWU, LD, SB, SH, SW, SD} lsu_op_t;
  typedef enum logic [1:0] {LSU_ST_IDLE, LSU_ST_WAIT, LSU_ST_RESP} lsu_state_t;
  typedef struct packed {
    logic       legal;
    logic       st;
    logic       sgn;
    logic [1:0] size;
  } op_info_t;
  // size is log2 of the access width in bytes; 64-bit-only ops are illegal on a 32-bit datapath
  function automatic op_info_t op_decode(input logic [3:0] op, input int data_w);
    op_info_t d;
    case (op)
      LB:      d = '{1'b1, 1'b0, 1'b1, 2'd0};
      LBU:     d = '{1'b1, 1'b0, 1'b0, 2'd0};
      LH:      d = '{1'b1, 1'b0, 1'b1, 2'd1};
      LHU:     d = '{1'b1, 1'b0, 1'b0, 2'd1};
      LW:      d = '{1'b1, 1'b0, 1'b1, 2'd2};
      LWU:     d = '{data_w == 64, 1'b0, 1'b0, 2'd2};
      LD:      d = '{data_w == 64, 1'b0, 1'b0, 2'd3};
      SB:      d = '{1'b1, 1'b1, 1'b0, 2'd0};
      SH:      d = '{1'b1, 1'b1, 1'b0, 2'd1};
      SW:      d = '{1'b1, 1'b1, 1'b0, 2'd2};
      SD:      d = '{data_w == 64, 1'b1, 1'b0, 2'd3};
      default: d = '0;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: big-endian store lane replication/byte enables and load extract/extend
module lsu_lane_align #(
  parameter int DATA_W = 32,
  parameter int NB = DATA_W / 8,
  parameter int K = $clog2(NB)
) (
  input  logic [1:0]        st_size,
  input  logic [K-1:0]      st_off,
  input  logic [DATA_W-1:0] st_data,
  output logic [NB-1:0]     st_we,
  output logic [DATA_W-1:0] st_wdata,
  input  logic [1:0]        ld_size,
  input  logic              ld_sgn,
  input  logic [K-1:0]      ld_off,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_data
);
  logic [DATA_W-1:0] sh;
  logic signed [DATA_W-1:0] sx;
  logic [7:0] rs;
  // offset 0 is the MSB lane: shift the addressed lane to the top, then shift back down to extend
  always_comb begin
    st_wdata = st_size == 2'd0 ? {NB{st_data[7:0]}} :
               st_size == 2'd1 ? {(NB/2){st_data[15:0]}} :
               st_size == 2'd2 ? {(NB/4){st_data[31:0]}} : st_data;
    st_we = ({NB{1'b1}} << (NB - (1 << st_size))) >> st_off;
    sh = ld_rdata << {ld_off, 3'b000};
    rs = 8'(DATA_W - (8 << ld_size));
    sx = $signed(sh) >>> rs;
    ld_data = ld_sgn ? sx : sh >> rs;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage LSU with valid/ready, MEM_LAT read wait and lane alignment; LSU_MISALIGN_TRAP_EN traps misaligned accesses
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MEM_LAT = 1,
  parameter int TAG_W = 5
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                busy,
  output logic                misalign,
  output logic [ADDR_W-1:0]   misalign_addr
);
  localparam int NB = DATA_W / 8;
  localparam int K = $clog2(NB);
  lsu_state_t state, state_nx;
  op_info_t dec;
  logic [2:0] cnt;
  logic [K-1:0] size_mask, off, ld_off;
  logic drop, hs, go, ld_go, done, ld_sgn;
  logic [1:0] ld_size;
  logic [TAG_W-1:0] ld_tag;
  logic [NB-1:0] st_we;
  logic [DATA_W-1:0] st_wdata, ld_data;
  assign dec = op_decode(req_op, DATA_W);
  assign size_mask = K'((4'd1 << dec.size) - 4'd1);
`ifdef LSU_MISALIGN_TRAP_EN
  assign off = req_addr[K-1:0];
  assign drop = |(off & size_mask);
  // report a misaligned request one cycle after it is accepted and remember its address
  always_ff @(posedge CLK)
    if (reset) begin
      misalign <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign <= hs & drop;
      if (hs & drop) misalign_addr <= req_addr;
    end
`else
  assign off = req_addr[K-1:0] & ~size_mask;
  assign drop = 1'b0;
  assign misalign = 1'b0;
  assign misalign_addr = '0;
`endif
  assign req_ready = ~reset & (state == LSU_ST_IDLE | (state == LSU_ST_RESP & rsp_ready));
  assign hs = req_valid & req_ready;
  assign go = hs & dec.legal & ~drop;
  assign ld_go = go & ~dec.st;
  assign done = state == LSU_ST_WAIT & cnt == 3'(MEM_LAT);
  assign busy = state != LSU_ST_IDLE;
  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .st_size (dec.size),
    .st_off  (off),
    .st_data (req_wdata),
    .st_we   (st_we),
    .st_wdata(st_wdata),
    .ld_size (ld_size),
    .ld_sgn  (ld_sgn),
    .ld_off  (ld_off),
    .ld_rdata(mem_rdata),
    .ld_data (ld_data)
  );
  // next state: a released response may chain straight into the next load
  always_comb begin
    state_nx = state == LSU_ST_IDLE ? (ld_go ? LSU_ST_WAIT : LSU_ST_IDLE) :
               state == LSU_ST_WAIT ? (done ? LSU_ST_RESP : LSU_ST_WAIT) :
               rsp_ready ? (ld_go ? LSU_ST_WAIT : LSU_ST_IDLE) : LSU_ST_RESP;
  end
  // state, latency counter, registered memory port and held response
  always_ff @(posedge CLK)
    if (reset) begin
      state <= LSU_ST_IDLE;
      cnt <= '0;
      mem_en <= 1'b0;
      mem_we <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_tag <= '0;
      ld_size <= '0;
      ld_sgn <= 1'b0;
      ld_off <= '0;
      ld_tag <= '0;
    end else begin
      state <= state_nx;
      cnt <= state == LSU_ST_WAIT & ~done ? cnt + 3'd1 : 3'd0;
      mem_en <= go;
      mem_we <= go & dec.st ? st_we : '0;
      if (go) begin
        mem_addr <= {req_addr[ADDR_W-1:K], {K{1'b0}}};
        mem_wdata <= dec.st ? st_wdata : '0;
      end
      if (ld_go) begin
        ld_size <= dec.size;
        ld_sgn <= dec.sgn;
        ld_off <= off;
        ld_tag <= req_tag;
      end
      if (done) begin
        rsp_valid <= 1'b1;
        rsp_data <= ld_data;
        rsp_tag <= ld_tag;
      end else if (state == LSU_ST_RESP & rsp_ready) rsp_valid <= 1'b0;
    end
endmodule
